alu_frame_ctrl: RTL and testbench



---
 rtl/alu_sys_pkg.sv | 50 +++++
 rtl/alu_frame_ctrl_if.sv | 21 ++
 rtl/alu_frame_tx.sv | 59 +++++
 rtl/alu_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU command path: function codes, frame headers,
// flag bit positions and the frame controller state encoding.
package alu_sys_pkg;

    localparam int BYTE_W = 8;
    localparam int FLAG_W = 4;

    localparam logic [3:0] FUN_ADD    = 4'h0;
    localparam logic [3:0] FUN_SUB    = 4'h1;
    localparam logic [3:0] FUN_MUL    = 4'h2;
    localparam logic [3:0] FUN_DIV    = 4'h3;
    localparam logic [3:0] FUN_AND    = 4'h4;
    localparam logic [3:0] FUN_OR     = 4'h5;
    localparam logic [3:0] FUN_NAND   = 4'h6;
    localparam logic [3:0] FUN_NOR    = 4'h7;
    localparam logic [3:0] FUN_XOR    = 4'h8;
    localparam logic [3:0] FUN_XNOR   = 4'h9;
    localparam logic [3:0] FUN_CMP_EQ = 4'hA;
    localparam logic [3:0] FUN_CMP_GT = 4'hB;
    localparam logic [3:0] FUN_SHL    = 4'hC;
    localparam logic [3:0] FUN_SHR    = 4'hD;
    localparam logic [3:0] FUN_NOP    = 4'hF;

    localparam logic [7:0] HDR_FULL  = 8'hCC;
    localparam logic [7:0] HDR_REUSE = 8'hDD;

    // Bit positions inside the {Arith, Logic, CMP, Shift} flag nibble.
    localparam int FLG_SHIFT = 0;
    localparam int FLG_CMP   = 1;
    localparam int FLG_LOGIC = 2;
    localparam int FLG_ARITH = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_A0,
        ST_RX_A1,
        ST_RX_B0,
        ST_RX_B1,
        ST_RX_FUN,
        ST_EXEC,
        ST_TX_LO,
        ST_TX_HI,
        ST_TX_FLG
    } frame_state_e;

    function automatic logic is_rx_state(input frame_state_e s);
        return s inside {ST_RX_A0, ST_RX_A1, ST_RX_B0, ST_RX_B1, ST_RX_FUN};
    endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// Byte-wide command receive and response transmit streams of the frame controller.
interface alu_frame_ctrl_if;

    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (
        output RX_DATA, RX_VALID, TX_READY,
        input  RX_READY, TX_DATA, TX_VALID
    );

    modport slave (
        input  RX_DATA, RX_VALID, TX_READY,
        output RX_READY, TX_DATA, TX_VALID
    );

endinterface

// File: rtl/alu_frame_tx.sv
// Response serializer: captures ALU result and flags on load, then presents
// result low byte, result high byte and flag byte under valid/ready.
module alu_frame_tx #(
    parameter int ALU_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ALU_W-1:0] load_result,
    input  logic [3:0]       load_flags,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             tx_fire
);
    import alu_sys_pkg::*;

    localparam int RES_BYTES = ALU_W / BYTE_W;
    localparam int N_BYTES   = RES_BYTES + 1;
    localparam int IDX_W     = $clog2(N_BYTES);

    logic [ALU_W-1:0]  result_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              valid_reg;
    logic [BYTE_W-1:0] resp_byte [N_BYTES];

    for (genvar gi = 0; gi < RES_BYTES; gi++) begin : g_res_byte
        assign resp_byte[gi] = result_reg[gi*BYTE_W +: BYTE_W];
    end
    assign resp_byte[RES_BYTES] = {{(BYTE_W-FLAG_W){1'b0}}, flags_reg};

    // Byte selection only moves on a transfer, so TX_DATA holds during a stall.
    assign tx_data  = resp_byte[idx_reg];
    assign tx_valid = valid_reg;
    assign tx_fire  = valid_reg & tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            flags_reg  <= '0;
            idx_reg    <= '0;
            valid_reg  <= 1'b0;
        end else if (load) begin
            result_reg <= load_result;
            flags_reg  <= load_flags;
            idx_reg    <= '0;
            valid_reg  <= 1'b1;
        end else if (tx_fire) begin
            if (idx_reg == IDX_W'(N_BYTES - 1)) begin
                idx_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Command sequencer in front of the system ALU: parses byte frames, runs one
// ALU operation, and returns the captured result through the response serializer.
module alu_frame_ctrl #(
    parameter int         ALU_W     = 16,
    parameter int         FUN_W     = 4,
    parameter int         ALU_LAT   = 1,
    parameter int         TIMEOUT   = 64,
    parameter logic [7:0] HDR_FULL  = alu_sys_pkg::HDR_FULL,
    parameter logic [7:0] HDR_REUSE = alu_sys_pkg::HDR_REUSE
) (
    input  logic             CLK,
    input  logic             RST,
    alu_frame_ctrl_if.slave  bus,
    output logic [ALU_W-1:0] ALU_A,
    output logic [ALU_W-1:0] ALU_B,
    output logic [FUN_W-1:0] ALU_FUN,
    input  logic [ALU_W-1:0] ALU_OUT,
    input  logic [3:0]       ALU_FLAGS,
    output logic             BUSY,
    output logic             ERR
);
    import alu_sys_pkg::*;

    localparam int EXEC_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam int TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FUN_W-1:0] FUN_IDLE = '1;

    frame_state_e      state_reg;
    logic [ALU_W-1:0]  alu_a_reg, alu_b_reg;
    logic [FUN_W-1:0]  alu_fun_reg;
    logic [EXEC_W-1:0] exec_cnt_reg;
    logic [TO_W-1:0]   tmo_cnt_reg;
    logic              rx_ready_reg, busy_reg, err_reg;
    logic              rx_fire, capture, tmo_hit, tmo_last, tx_fire;

    assign rx_fire  = bus.RX_VALID & rx_ready_reg;
    assign capture  = (state_reg == ST_EXEC) && (exec_cnt_reg == EXEC_W'(ALU_LAT));
    assign tmo_hit  = (TIMEOUT != 0) && is_rx_state(state_reg) && (tmo_cnt_reg == TO_W'(TIMEOUT));
    assign tmo_last = (TIMEOUT != 0) && (tmo_cnt_reg == TO_W'(TIMEOUT - 1));

    assign ALU_A        = alu_a_reg;
    assign ALU_B        = alu_b_reg;
    assign ALU_FUN      = alu_fun_reg;
    assign BUSY         = busy_reg;
    assign ERR          = err_reg;
    assign bus.RX_READY = rx_ready_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_fun_reg  <= FUN_IDLE;
            exec_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            rx_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tmo_cnt_reg <= '0;
                    if (rx_fire) begin
                        if (bus.RX_DATA == HDR_FULL) begin
                            state_reg <= ST_RX_A0;
                            busy_reg  <= 1'b1;
                        end else if (bus.RX_DATA == HDR_REUSE) begin
                            state_reg <= ST_RX_FUN;
                            busy_reg  <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_RX_A0, ST_RX_A1, ST_RX_B0, ST_RX_B1, ST_RX_FUN: begin
                    if (tmo_hit) begin
                        state_reg    <= ST_IDLE;
                        err_reg      <= 1'b1;
                        busy_reg     <= 1'b0;
                        rx_ready_reg <= 1'b1;
                        tmo_cnt_reg  <= '0;
                    end else if (rx_fire) begin
                        tmo_cnt_reg <= '0;
                        case (state_reg)
                            ST_RX_A0: begin
                                alu_a_reg[BYTE_W-1:0] <= bus.RX_DATA;
                                state_reg             <= ST_RX_A1;
                            end
                            ST_RX_A1: begin
                                alu_a_reg[ALU_W-1:BYTE_W] <= bus.RX_DATA;
                                state_reg                 <= ST_RX_B0;
                            end
                            ST_RX_B0: begin
                                alu_b_reg[BYTE_W-1:0] <= bus.RX_DATA;
                                state_reg             <= ST_RX_B1;
                            end
                            ST_RX_B1: begin
                                alu_b_reg[ALU_W-1:BYTE_W] <= bus.RX_DATA;
                                state_reg                 <= ST_RX_FUN;
                            end
                            default: begin
                                alu_fun_reg  <= bus.RX_DATA[FUN_W-1:0];
                                exec_cnt_reg <= '0;
                                rx_ready_reg <= 1'b0;
                                state_reg    <= ST_EXEC;
                            end
                        endcase
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt_reg <= tmo_cnt_reg + TO_W'(1);
                        // Close the door one cycle early so no byte is taken and lost by the abort.
                        if (tmo_last) begin
                            rx_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (capture) begin
                        alu_fun_reg <= FUN_IDLE;
                        state_reg   <= ST_TX_LO;
                    end else begin
                        exec_cnt_reg <= exec_cnt_reg + EXEC_W'(1);
                    end
                end
                ST_TX_LO: if (tx_fire) state_reg <= ST_TX_HI;
                ST_TX_HI: if (tx_fire) state_reg <= ST_TX_FLG;
                ST_TX_FLG: begin
                    if (tx_fire) begin
                        state_reg    <= ST_IDLE;
                        busy_reg     <= 1'b0;
                        rx_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    busy_reg     <= 1'b0;
                    rx_ready_reg <= 1'b1;
                    alu_fun_reg  <= FUN_IDLE;
                end
            endcase
        end
    end

    alu_frame_tx #(
        .ALU_W(ALU_W)
    ) u_tx (
        .clk        (CLK),
        .rst        (RST),
        .load       (capture),
        .load_result(ALU_OUT),
        .load_flags (ALU_FLAGS),
        .tx_ready   (bus.TX_READY),
        .tx_data    (bus.TX_DATA),
        .tx_valid   (bus.TX_VALID),
        .tx_fire    (tx_fire)
    );

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Directed bench for alu_frame_ctrl with a small registered ALU stand-in.
`timescale 1ns/1ps
module tb_alu_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] ALU_A, ALU_B, ALU_OUT;
    logic [3:0]  ALU_FUN, ALU_FLAGS;
    logic        BUSY, ERR;

    alu_frame_ctrl_if bus();

    alu_frame_ctrl #(.TIMEOUT(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .ALU_A    (ALU_A),
        .ALU_B    (ALU_B),
        .ALU_FUN  (ALU_FUN),
        .ALU_OUT  (ALU_OUT),
        .ALU_FLAGS(ALU_FLAGS),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Registered ALU stand-in: ADD, AND and shift-right-by-one of A.
    always @(posedge CLK) begin
        case (ALU_FUN)
            4'h0:    begin ALU_OUT <= ALU_A + ALU_B; ALU_FLAGS <= 4'b1000; end
            4'h4:    begin ALU_OUT <= ALU_A & ALU_B; ALU_FLAGS <= 4'b0100; end
            4'hD:    begin ALU_OUT <= ALU_A >> 1;    ALU_FLAGS <= 4'b0001; end
            default: begin ALU_OUT <= 16'h0;         ALU_FLAGS <= 4'b0000; end
        endcase
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tx_q[$];
    int         tx_rd = 0;
    int         fun_cycles = 0;
    logic [3:0] last_fun = 4'hF;
    int         err_cycles = 0;

    always @(negedge CLK) begin
        if (bus.TX_VALID && bus.TX_READY) tx_q.push_back(bus.TX_DATA);
        if (ALU_FUN != 4'hF) begin
            fun_cycles++;
            last_fun = ALU_FUN;
        end
        if (ERR) err_cycles++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_alu_a"}, ALU_A, 16'h0);
        check_val({tag, "_alu_b"}, ALU_B, 16'h0);
        check_val({tag, "_alu_fun"}, ALU_FUN, 4'hF);
        check_val({tag, "_tx_data"}, bus.TX_DATA, 8'h00);
        check_val({tag, "_tx_valid"}, bus.TX_VALID, 1'b0);
        check_val({tag, "_busy"}, BUSY, 1'b0);
        check_val({tag, "_err"}, ERR, 1'b0);
        check_val({tag, "_rx_ready"}, bus.RX_READY, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        @(negedge CLK);
        bus.RX_DATA  = d;
        bus.RX_VALID = 1'b1;
        while (!bus.RX_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check_val("rx_ready_wait", 32'(bus.RX_READY), 32'd1);
        @(posedge CLK);
        #1;
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_full(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        send_byte(8'hCC);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(b[7:0]);
        send_byte(b[15:8]);
        send_byte({4'h0, f});
        $display("frame full a=%h b=%h fun=%h", a, b, f);
    endtask

    task automatic send_reuse(input logic [3:0] f);
        send_byte(8'hDD);
        send_byte({4'hA, f});
        $display("frame reuse fun=%h", f);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < tx_rd + n && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check_val("tx_count", 32'(tx_q.size() >= tx_rd + n), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_tx_valid();
        int k = 0;
        while (!bus.TX_VALID && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check_val("tx_valid_wait", 32'(bus.TX_VALID), 32'd1);
    endtask

    task automatic check_resp(input string tag, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp_b [3];
        logic [7:0] obs;
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        for (int i = 0; i < 3; i++) begin
            obs = (tx_q.size() > tx_rd + i) ? tx_q[tx_rd + i] : 8'hXX;
            check_val($sformatf("%s_byte%0d", tag, i), obs, exp_b[i]);
        end
        $display("response %s: %h %h %h", tag, e0, e1, e2);
        tx_rd += 3;
    endtask

    initial begin
        int f0, e0, n;
        logic [7:0] bp_exp [3];
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;
        bus.TX_READY = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_reset("init");

        // Full ADD frame
        f0 = fun_cycles;
        send_full(16'h000F, 16'h000A, 4'h0);
        check_val("add_alu_a", ALU_A, 16'h000F);
        check_val("add_alu_b", ALU_B, 16'h000A);
        wait_tx(3);
        check_resp("add", 8'h19, 8'h00, 8'h08);
        check_val("add_fun_cycles", fun_cycles - f0, 2);
        check_val("add_fun_code", last_fun, 4'h0);
        check_val("add_busy_done", BUSY, 1'b0);
        check_val("add_tx_valid_done", bus.TX_VALID, 1'b0);

        // Reuse operands with AND
        f0 = fun_cycles;
        send_reuse(4'h4);
        wait_tx(3);
        check_resp("and", 8'h0A, 8'h00, 8'h04);
        check_val("and_alu_a", ALU_A, 16'h000F);
        check_val("and_alu_b", ALU_B, 16'h000A);
        check_val("and_fun_cycles", fun_cycles - f0, 2);
        check_val("and_fun_code", last_fun, 4'h4);
        check_val("and_fun_idle", ALU_FUN, 4'hF);

        // Bad header
        e0 = err_cycles;
        send_byte(8'h55);
        $display("bad header 55");
        check_val("badhdr_err", ERR, 1'b1);
        repeat (4) begin @(posedge CLK); #1; end
        check_val("badhdr_err_len", err_cycles - e0, 1);
        check_val("badhdr_busy", BUSY, 1'b0);
        check_val("badhdr_no_tx", tx_q.size(), tx_rd);
        send_full(16'h0009, 16'h0003, 4'hD);
        wait_tx(3);
        check_resp("shr", 8'h04, 8'h00, 8'h01);

        // Backpressure: 5 stalled cycles per response byte
        bus.TX_READY = 1'b0;
        send_full(16'h000F, 16'h000A, 4'h0);
        wait_tx_valid();
        bp_exp[0] = 8'h19;
        bp_exp[1] = 8'h00;
        bp_exp[2] = 8'h08;
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge CLK);
                check_val($sformatf("bp_valid%0d", b), bus.TX_VALID, 1'b1);
                check_val($sformatf("bp_data%0d", b), bus.TX_DATA, bp_exp[b]);
                check_val($sformatf("bp_rx_ready%0d", b), bus.RX_READY, 1'b0);
            end
            @(posedge CLK); #1;
            bus.TX_READY = 1'b1;
            @(posedge CLK); #1;
            bus.TX_READY = 1'b0;
        end
        check_val("bp_count", tx_q.size() - tx_rd, 3);
        check_resp("bp", 8'h19, 8'h00, 8'h08);
        check_val("bp_busy_done", BUSY, 1'b0);
        check_val("bp_valid_done", bus.TX_VALID, 1'b0);
        bus.TX_READY = 1'b1;

        // Timeout after a partial frame
        send_byte(8'hCC);
        send_byte(8'h01);
        n = 0;
        while (!ERR && n < 100) begin @(posedge CLK); #1; n++; end
        $display("timeout after %0d cycles", n);
        check_val("tmo_latency", n, 17);
        check_val("tmo_busy", BUSY, 1'b0);
        check_val("tmo_rx_ready", bus.RX_READY, 1'b1);
        check_val("tmo_alu_a_kept", ALU_A, 16'h0001);
        @(posedge CLK); #1;
        check_val("tmo_err_len", ERR, 1'b0);
        send_full(16'h000F, 16'h000A, 4'h0);
        wait_tx(3);
        check_resp("tmo_next", 8'h19, 8'h00, 8'h08);

        // Reset during EXEC
        send_full(16'h0003, 16'h0002, 4'h0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_reset("rst_exec");
        repeat (6) begin @(posedge CLK); #1; end
        check_val("rst_exec_no_tx", tx_q.size(), tx_rd);
        check_val("rst_exec_valid", bus.TX_VALID, 1'b0);
        send_full(16'h000F, 16'h000A, 4'h0);
        wait_tx(3);
        check_resp("rst_exec_next", 8'h19, 8'h00, 8'h08);

        // Reset during TX_HI
        bus.TX_READY = 1'b0;
        send_full(16'h000F, 16'h000A, 4'h0);
        wait_tx_valid();
        @(posedge CLK); #1;
        bus.TX_READY = 1'b1;
        @(posedge CLK); #1;
        bus.TX_READY = 1'b0;
        check_val("txhi_data", bus.TX_DATA, 8'h00);
        check_val("txhi_valid", bus.TX_VALID, 1'b1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check_reset("rst_txhi");
        tx_rd = tx_q.size();
        bus.TX_READY = 1'b1;
        send_full(16'h1234, 16'h0101, 4'h0);
        wait_tx(3);
        check_resp("rst_txhi_next", 8'h35, 8'h13, 8'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
